// File: rtl/body_mem_loader.sv
// Body RAM front-end writer: streams N records into the RAM write port from BASE_ADDR,
// then pulses sim_start to the core, waits for sim_done and reports completion.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for load_go
// S_LOAD  | accepting records, one RAM write per handshake
// S_FLUSH | last write is on the RAM port, no more records accepted
// S_KICK  | sim_start high for this cycle
// S_WAIT  | waiting for sim_done from the core
// S_FIN   | load_done high for this cycle, then back to idle
module body_mem_loader #(
    parameter int N         = 2,
    parameter int BASE_ADDR = 0,
    parameter int AW        = 15,
    parameter int DW        = 80
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_go,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] wr_data,
    output logic [AW-1:0] wr_addr,
    output logic          wr_en,
    output logic          sim_start,
    input  logic          sim_done,
    output logic          busy,
    output logic          load_done,
    output logic [AW:0]   loaded_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_KICK,
        S_WAIT,
        S_FIN
    } state_t;

    localparam logic [AW:0]   LAST = (AW+1)'(N - 1);
    localparam logic [AW-1:0] BASE = AW'(BASE_ADDR);

    state_t state;

    // loaded_count doubles as the record index; the address add wraps silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            in_ready     <= 1'b0;
            wr_data      <= '0;
            wr_addr      <= '0;
            wr_en        <= 1'b0;
            sim_start    <= 1'b0;
            busy         <= 1'b0;
            load_done    <= 1'b0;
            loaded_count <= '0;
        end else begin
            wr_en     <= 1'b0;
            sim_start <= 1'b0;
            load_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load_go) begin
                        state        <= S_LOAD;
                        in_ready     <= 1'b1;
                        busy         <= 1'b1;
                        loaded_count <= '0;
                    end
                end
                S_LOAD: begin
                    if (in_valid && in_ready) begin
                        wr_en        <= 1'b1;
                        wr_data      <= in_data;
                        wr_addr      <= BASE + loaded_count[AW-1:0];
                        loaded_count <= loaded_count + 1'b1;
                        if (loaded_count == LAST) begin
                            state    <= S_FLUSH;
                            in_ready <= 1'b0;
                        end
                    end
                end
                S_FLUSH: begin
                    state     <= S_KICK;
                    sim_start <= 1'b1;
                end
                S_KICK: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (sim_done) begin
                        state     <= S_FIN;
                        load_done <= 1'b1;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_body_mem_loader.sv
// Bench for body_mem_loader: N=4 records at base 0x7FFE so every session wraps the address,
// with a timing-rule model checked every cycle plus directed literal checks and RAM read-back.
module tb_body_mem_loader;

    localparam int N    = 4;
    localparam int BASE = 32'h7FFE;
    localparam int AW   = 15;
    localparam int DW   = 80;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_go;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic          sim_start;
    logic          sim_done;
    logic          busy;
    logic          load_done;
    logic [AW:0]   loaded_count;

    body_mem_loader #(.N(N), .BASE_ADDR(BASE), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .load_go(load_go),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
        .sim_start(sim_start), .sim_done(sim_done), .busy(busy),
        .load_done(load_done), .loaded_count(loaded_count)
    );

    always #5 clk = ~clk;

    // Dual-port RAM: write port from the loader, read port with one-cycle latency.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_q;
    always @(posedge clk) begin
        if (wr_en) ram[wr_addr] <= wr_data;
        rd_q <= ram[rd_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: session events in cycle numbers. Cycle e is the interval after rising edge e.
    // last_c = cycle of final handshake; done_c = cycle sim_done was seen in the wait window.
    int            cyc = 0;
    bit            m_active;
    int            m_count;
    int            last_c;
    int            done_c;
    bit            x_ready, x_wren, x_start, x_busy, x_done;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_data;

    always @(posedge clk) begin
        bit hs;
        cyc++;
        hs = x_ready && in_valid;
        if (reset) begin
            m_active = 0; m_count = 0; last_c = -1; done_c = -1;
            x_ready = 0; x_wren = 0; x_start = 0; x_busy = 0; x_done = 0;
            x_addr = '0; x_data = '0;
        end else begin
            x_wren = 0;
            if (!m_active) begin
                if (load_go) begin
                    m_active = 1; m_count = 0; last_c = -1; done_c = -1;
                end
            end else begin
                if (hs) begin
                    x_wren  = 1;
                    x_addr  = AW'((BASE + m_count) % (1 << AW));
                    x_data  = in_data;
                    m_count = m_count + 1;
                    if (m_count == N) last_c = cyc - 1;
                end
                if (last_c >= 0 && done_c < 0 && (cyc - 1) >= last_c + 3 && sim_done)
                    done_c = cyc - 1;
                if (done_c >= 0 && cyc == done_c + 2) m_active = 0;
            end
            x_ready = m_active && last_c < 0;
            x_start = m_active && last_c >= 0 && cyc == last_c + 2;
            x_done  = m_active && done_c >= 0 && cyc == done_c + 1;
            x_busy  = m_active;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, x_ready);
        chk("wr_en", wr_en, x_wren);
        chk("wr_addr", wr_addr, x_addr);
        chk("wr_data", wr_data, x_data);
        chk("sim_start", sim_start, x_start);
        chk("busy", busy, x_busy);
        chk("load_done", load_done, x_done);
        chk("loaded_count", loaded_count, m_count);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go();
        load_go = 1'b1;
        step();
        load_go = 1'b0;
    endtask

    // Offer n_rec records seed+k; after each valid cycle insert gap idle cycles.
    int last_acc;
    task automatic feed(input int n_rec, input int gap, input logic [DW-1:0] seed);
        int k = 0;
        int ph = 0;
        int budget = 100;
        bit hs;
        while (k < n_rec && budget > 0) begin
            in_valid = (ph == 0);
            in_data  = seed + k;
            hs = in_valid && in_ready;
            if (hs) last_acc = cyc;
            step();
            if (hs) k++;
            ph = (ph == gap) ? 0 : ph + 1;
            budget--;
        end
        in_valid = 1'b0;
        chk("feed_accepted", k, n_rec);
    endtask

    task automatic wait_start(output int c);
        c = -1;
        for (int i = 0; i < 20; i++) begin
            if (sim_start) begin
                c = cyc;
                break;
            end
            step();
        end
    endtask

    task automatic wait_done(output int n, output int first);
        n = 0;
        first = -1;
        for (int i = 0; i < 8; i++) begin
            if (load_done) begin
                n++;
                if (first < 0) first = cyc;
            end
            step();
        end
    endtask

    task automatic rd_chk(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        rd_addr = a;
        step();
        chk(name, rd_q, exp);
    endtask

    localparam logic [DW-1:0] S1 = 80'h0123_4567_89AB_CDEF_AAAA;
    localparam logic [DW-1:0] S2 = 80'hFEDC_BA98_7654_3210_BBBB;
    localparam logic [DW-1:0] S3 = 80'h5555_0000_1111_2222_CCCC;
    localparam logic [DW-1:0] S4 = 80'h0F0F_0F0F_0F0F_0F0F_DDDD;
    localparam logic [DW-1:0] S5 = 80'h7777_8888_9999_AAAA_0000;

    initial begin
        int sc, nd, fd;
        reset = 1'b1; load_go = 1'b0; in_valid = 1'b0; in_data = '0;
        sim_done = 1'b0; rd_addr = '0;
        step(); step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", loaded_count, 0);
        reset = 1'b0;
        step();

        // streaming load, wraps 0x7FFE..0x0001
        go();
        chk("s1_ready_after_go", in_ready, 1);
        feed(N, 0, S1);
        wait_start(sc);
        chk("s1_start_latency", sc - last_acc, 2);
        step(); step();
        sim_done = 1'b1; step(); sim_done = 1'b0;
        wait_done(nd, fd);
        chk("s1_done_pulses", nd, 1);
        chk("s1_busy_idle", busy, 0);
        chk("s1_count", loaded_count, 4);
        rd_chk("s1_rd_7ffe", 15'h7FFE, S1);
        rd_chk("s1_rd_7fff", 15'h7FFF, S1 + 1);
        rd_chk("s1_rd_0000", 15'h0000, S1 + 2);
        rd_chk("s1_rd_0001", 15'h0001, S1 + 3);

        // stalled source 1,0,0,1,... and a spurious load_go during WAIT
        go();
        feed(N, 2, S2);
        wait_start(sc);
        chk("s2_start_latency", sc - last_acc, 2);
        step();
        load_go = 1'b1; step(); load_go = 1'b0;
        step(); step();
        sim_done = 1'b1; step(); sim_done = 1'b0;
        wait_done(nd, fd);
        chk("s2_done_pulses", nd, 1);
        chk("s2_count_kept", loaded_count, 4);
        chk("s2_busy_idle", busy, 0);
        rd_chk("s2_rd_7ffe", 15'h7FFE, S2);
        rd_chk("s2_rd_0001", 15'h0001, S2 + 3);

        // sim_done held high from FLUSH onward
        go();
        feed(N, 0, S3);
        sim_done = 1'b1;
        wait_done(nd, fd);
        sim_done = 1'b0;
        chk("s3_done_pulses", nd, 1);
        chk("s3_done_latency", fd - last_acc, 4);
        chk("s3_busy_idle", busy, 0);

        // reset after two of four records
        go();
        feed(2, 0, S4);
        reset = 1'b1; step(); reset = 1'b0;
        chk("s4_rst_in_ready", in_ready, 0);
        chk("s4_rst_wr_en", wr_en, 0);
        chk("s4_rst_busy", busy, 0);
        chk("s4_rst_start", sim_start, 0);
        step();
        chk("s4_no_start", sim_start, 0);
        rd_chk("s4_rd_7ffe", 15'h7FFE, S4);
        rd_chk("s4_rd_7fff", 15'h7FFF, S4 + 1);
        rd_chk("s4_rd_0000_old", 15'h0000, S3 + 2);
        go();
        chk("s5_count_clear", loaded_count, 0);
        feed(1, 0, S5);
        chk("s5_first_addr", wr_addr, 15'h7FFE);
        chk("s5_first_data", wr_data, S5);
        feed(3, 0, S5 + 1);
        wait_start(sc);
        chk("s5_start_latency", sc - last_acc, 2);
        step();
        sim_done = 1'b1; step(); sim_done = 1'b0;
        wait_done(nd, fd);
        chk("s5_done_pulses", nd, 1);
        rd_chk("s5_rd_0001", 15'h0001, S5 + 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/body_mem_loader.md
# body_mem_loader

Front-end writer for the N-body engine's dual-port body RAM. It accepts N body records over a valid/ready stream and drives the RAM write port (data, wraddress, wren) at consecutive addresses from a base. It then issues a one-cycle start pulse to the simulation core, waits for its done, and reports completion. The core and benches read the same RAM through the other port.

## Interface
- N, 2: number of body records per load session; legal range 1 to 2^AW.
- BASE_ADDR, 0: RAM word address of record 0.
- AW, 15: RAM address width.
- DW, 80: RAM word width. Records are opaque 80-bit words, written unchanged.

- clk  in  1  single clock; everything is synchronous to its rising edge.
- reset  in  1  synchronous, active-high reset.
- load_go  in  1  starts a session; sampled only in IDLE.
- in_data  in  DW  body record.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts in_data this cycle.
- wr_data  out  DW  to RAM data.
- wr_addr  out  AW  to RAM wraddress.
- wr_en  out  1  to RAM wren.
- sim_start  out  1  one-cycle start pulse to the core.
- sim_done  in  1  core completion; level or pulse.
- busy  out  1  high in every state except IDLE.
- load_done  out  1  one-cycle pulse when the session completes.
- loaded_count  out  AW+1  records accepted in the current or last session.

## Operation
- States: IDLE, LOAD, FLUSH, KICK, WAIT, FIN.
- **IDLE**
  - load_go=1 -> LOAD; clear the index and loaded_count.
  - Otherwise stay in IDLE.
- **LOAD**
  - in_ready=1.
  - A handshake (in_valid & in_ready) captures in_data, the address BASE_ADDR+idx, and wr_en=1 into output registers. idx and loaded_count then increment.
  - When the handshake accepts record N-1 -> FLUSH.
  - No handshake: wr_en=0 next cycle.
- **FLUSH**
  - in_ready=0; the last write is on the port.
  - Always -> KICK.
- **KICK**
  - sim_start=1 for exactly this cycle.
  - Always -> WAIT.
- **WAIT**
  - sim_done=1 -> FIN.
  - sim_done is ignored in every other state, including KICK.
- **FIN**
  - load_done=1 for exactly this cycle.
  - Always -> IDLE.
- Address arithmetic: wr_addr = (BASE_ADDR + idx) mod 2^AW. Wrap past the top of RAM is silent, with no error flag.
- load_go asserted outside IDLE is ignored.
- in_data presented while in_ready=0 is not consumed, and the loader records no state for it.
- loaded_count holds its value after FIN until the next load_go.
- Reset mid-session:
  - Return to IDLE; all outputs reach their reset values on the next cycle.
  - RAM words already written stay written; there is no rollback.
  - Any in-flight sim_start is dropped.
- Reset values: in_ready=0, wr_en=0, wr_data=0, wr_addr=0, sim_start=0, busy=0, load_done=0, loaded_count=0.

## Timing
- Write latency: a handshake at cycle t puts wr_en/wr_addr/wr_data on the port at t+1. The RAM commits at the end of t+1.
- Throughput: one record per cycle. With in_valid held high, N records take N consecutive cycles and wr_en is high for N consecutive cycles.
- If the last handshake is at t:
  - FLUSH is at t+1 (last write on port).
  - KICK / sim_start is at t+2, so the start pulse always comes after the final write has committed.
  - WAIT begins at t+3.
- sim_done sampled at cycle u in WAIT gives load_done=1 at u+1 and IDLE at u+2.
- load_go at cycle s gives LOAD and in_ready=1 at s+1.
- in_ready is a registered function of state only. It does not depend combinationally on in_valid.
- Minimum session: load_go at 0, first accept at 1, N=1 gives sim_start at 3.

## Test plan
- **Streaming load:** N=2, BASE_ADDR=0. load_go, then in_valid held with records 0x...AAAA and 0x...BBBB.
  - wr_en high on two consecutive cycles at addresses 0 and 1.
  - sim_start exactly one cycle, two cycles after the last accept.
  - Read-back through the RAM read port (one-cycle read latency) returns both words.
- **Stalled source:** N=5, BASE_ADDR=0x190. Toggle in_valid 1,0,0,1,...
  - Writes land at 0x190..0x194 in order.
  - wr_en is low on stall cycles.
  - loaded_count=5 at FIN.
- **Handshake with the core:** hold sim_done=1 from before KICK.
  - It is ignored until WAIT.
  - load_done pulses exactly once, the cycle after WAIT is entered.
  - busy drops the cycle after that.
- **Address wrap:** BASE_ADDR=0x7FFF, N=2.
  - Writes land at 0x7FFF, then 0x0000.
- **Reset mid-LOAD:** assert reset after 2 of 4 records.
  - Next cycle: in_ready=0, wr_en=0, busy=0, no sim_start.
  - Words 0 and 1 remain in RAM.
  - A new load_go restarts at BASE_ADDR with loaded_count=0.
- **Spurious load_go:** pulse load_go during WAIT.
  - No effect.
  - The session completes normally and the loader returns to IDLE.
